// File: rtl/round_judge_if.sv
// Score-keeper / player bus of the round judge.
interface round_judge_if;
  logic        start;
  logic [2:0]  problem;
  logic        round_ack;
  logic        ans_a_valid;
  logic [1:0]  ans_a;
  logic        ans_b_valid;
  logic [1:0]  ans_b;
  logic        ready;
  logic        check1;
  logic        check2;
  logic        lock_a;
  logic        lock_b;
  logic [23:0] timer;
  logic        game_over;

  // Driver side: players and score keeper.
  modport master (
    output start, problem, round_ack, ans_a_valid, ans_a, ans_b_valid, ans_b,
    input  ready, check1, check2, lock_a, lock_b, timer, game_over
  );

  // Judge side.
  modport slave (
    input  start, problem, round_ack, ans_a_valid, ans_a, ans_b_valid, ans_b,
    output ready, check1, check2, lock_a, lock_b, timer, game_over
  );
endinterface

// File: rtl/round_judge.sv
// Per-question round controller: runs the answer window, latches each player's
// first answer, judges it against KEY and holds the verdict until round_ack.
module round_judge #(
  parameter int unsigned ROUND_CYCLES = 50_000_000,
  parameter int unsigned NUM_PROBLEMS = 5,
  parameter logic [15:0] KEY          = 16'h0000
) (
  input logic          clk,
  input logic          greset,
  round_judge_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StArmed, StVerdict, StGap, StDone} state_e;

  localparam logic [23:0] TimerLoad    = 24'(ROUND_CYCLES - 1);
  localparam logic [2:0]  ProblemLimit = 3'(NUM_PROBLEMS);

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        lock_a_q, lock_a_d, lock_b_q, lock_b_d;
  logic [1:0]  ans_a_q, ans_a_d, ans_b_q, ans_b_d;
  logic        ready_q, ready_d;
  logic        check1_q, check1_d, check2_q, check2_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  key_sel;

  assign key_sel = KEY[{bus.problem, 1'b0} +: 2];

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (greset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      lock_a_q    <= 1'b0;
      lock_b_q    <= 1'b0;
      ans_a_q     <= '0;
      ans_b_q     <= '0;
      ready_q     <= 1'b0;
      check1_q    <= 1'b0;
      check2_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lock_a_q    <= lock_a_d;
      lock_b_q    <= lock_b_d;
      ans_a_q     <= ans_a_d;
      ans_b_q     <= ans_b_d;
      ready_q     <= ready_d;
      check1_q    <= check1_d;
      check2_q    <= check2_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state: answer capture, window timing, verdict and round sequencing.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    lock_a_d    = lock_a_q;
    lock_b_d    = lock_b_q;
    ans_a_d     = ans_a_q;
    ans_b_d     = ans_b_q;
    ready_d     = ready_q;
    check1_d    = check1_q;
    check2_d    = check2_q;
    game_over_d = game_over_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StArmed;
          timer_d  = TimerLoad;
          lock_a_d = 1'b0;
          lock_b_d = 1'b0;
          ans_a_d  = '0;
          ans_b_d  = '0;
        end
      end
      StArmed: begin
        if (bus.ans_a_valid && !lock_a_q) begin
          ans_a_d  = bus.ans_a;
          lock_a_d = 1'b1;
        end
        if (bus.ans_b_valid && !lock_b_q) begin
          ans_b_d  = bus.ans_b;
          lock_b_d = 1'b1;
        end
        if (timer_q != '0) begin
          timer_d = timer_q - 24'd1;
        end
        // Judge on the next-state locks so a strobe on the closing edge counts.
        if (timer_q == '0 || (lock_a_d && lock_b_d)) begin
          state_d  = StVerdict;
          ready_d  = 1'b1;
          check1_d = lock_a_d && (ans_a_d == key_sel);
          check2_d = lock_b_d && (ans_b_d == key_sel);
        end
      end
      StVerdict: begin
        if (bus.round_ack) begin
          state_d  = StGap;
          ready_d  = 1'b0;
          check1_d = 1'b0;
          check2_d = 1'b0;
        end
      end
      StGap: begin
        // problem was advanced by the score keeper on the ack edge.
        if (bus.problem >= ProblemLimit) begin
          state_d     = StDone;
          game_over_d = 1'b1;
          timer_d     = '0;
          lock_a_d    = 1'b0;
          lock_b_d    = 1'b0;
        end else begin
          state_d  = StArmed;
          timer_d  = TimerLoad;
          lock_a_d = 1'b0;
          lock_b_d = 1'b0;
          ans_a_d  = '0;
          ans_b_d  = '0;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.check1    = check1_q;
  assign bus.check2    = check2_q;
  assign bus.lock_a    = lock_a_q;
  assign bus.lock_b    = lock_b_q;
  assign bus.timer     = timer_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge with a score-keeper model.
module tb_round_judge;
  localparam int          R    = 20;
  localparam int          NP   = 3;
  // Problem keys: p0=10, p1=10, p2=11.
  localparam logic [15:0] KEY  = 16'h003A;
  localparam int          MAXK = 40;

  logic clk = 1'b0;
  logic greset = 1'b1;

  round_judge_if rj();

  round_judge #(
    .ROUND_CYCLES(R),
    .NUM_PROBLEMS(NP),
    .KEY(KEY)
  ) dut (
    .clk(clk),
    .greset(greset),
    .bus(rj.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int sk_updates, sk_score_a, sk_score_b;
  int exp_score_a, exp_score_b;

  // Answer plan per edge index within a round (1..R).
  logic       a_v [0:MAXK];
  logic [1:0] a_d [0:MAXK];
  logic       b_v [0:MAXK];
  logic [1:0] b_d [0:MAXK];

  // Score keeper model: counts on a fresh ready and pulses round_ack once.
  always @(posedge clk) begin
    if (greset) begin
      rj.problem   <= '0;
      rj.round_ack <= 1'b0;
      sk_updates   <= 0;
      sk_score_a   <= 0;
      sk_score_b   <= 0;
    end else if (rj.ready && !rj.round_ack) begin
      rj.round_ack <= 1'b1;
      rj.problem   <= rj.problem + 3'd1;
      sk_updates   <= sk_updates + 1;
      sk_score_a   <= sk_score_a + (rj.check1 ? 1 : 0);
      sk_score_b   <= sk_score_b + (rj.check2 ? 1 : 0);
    end else begin
      rj.round_ack <= 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int k = 0; k <= MAXK; k++) begin
      a_v[k] = 1'b0; a_d[k] = 2'b00;
      b_v[k] = 1'b0; b_d[k] = 2'b00;
    end
  endtask

  // Plays one round from ARMED entry through GAP, checking against the rules.
  task automatic run_round(input string name, input int prob);
    int fa, fb, endk, base;
    logic [15:0] kk;
    logic [1:0]  key;
    logic        c1, c2, la, lb;
    kk = KEY >> (2 * prob);
    key = kk[1:0];
    fa = 0;
    fb = 0;
    for (int k = 1; k <= R; k++) begin
      if (a_v[k] && fa == 0) fa = k;
      if (b_v[k] && fb == 0) fb = k;
    end
    endk = R;
    if (fa != 0 && fb != 0) endk = (fa > fb) ? fa : fb;
    c1 = (fa != 0) && (a_d[fa] == key);
    c2 = (fb != 0) && (b_d[fb] == key);
    exp_score_a += c1 ? 1 : 0;
    exp_score_b += c2 ? 1 : 0;
    base = sk_updates;
    for (int k = 1; k <= endk; k++) begin
      rj.ans_a_valid = a_v[k]; rj.ans_a = a_d[k];
      rj.ans_b_valid = b_v[k]; rj.ans_b = b_d[k];
      tick();
      la = (fa != 0) && (fa <= k);
      lb = (fb != 0) && (fb <= k);
      n_checks++;
      if (rj.lock_a !== la || rj.lock_b !== lb) begin
        n_fail++;
        $display("FAIL %s locks at k=%0d: got %b%b want %b%b", name, k, rj.lock_a, rj.lock_b,
                 la, lb);
      end
      if (k < endk) begin
        n_checks++;
        if (rj.ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early ready at k=%0d: got %b want 0", name, k, rj.ready);
        end
        n_checks++;
        if (rj.timer !== 24'(R - 1 - k)) begin
          n_fail++;
          $display("FAIL %s timer at k=%0d: got %0d want %0d", name, k, rj.timer, R - 1 - k);
        end
      end else begin
        n_checks++;
        if (rj.ready !== 1'b1 || rj.check1 !== c1 || rj.check2 !== c2) begin
          n_fail++;
          $display("FAIL %s verdict: got r=%b c1=%b c2=%b want r=1 c1=%b c2=%b",
                   name, rj.ready, rj.check1, rj.check2, c1, c2);
        end
      end
    end
    // Wrong strobes during VERDICT must not disturb the held verdict.
    rj.ans_a_valid = 1'b1; rj.ans_a = ~key;
    rj.ans_b_valid = 1'b1; rj.ans_b = ~key;
    tick();
    n_checks++;
    if (rj.ready !== 1'b1 || rj.check1 !== c1 || rj.check2 !== c2) begin
      n_fail++;
      $display("FAIL %s verdict hold: got r=%b c1=%b c2=%b want r=1 c1=%b c2=%b",
               name, rj.ready, rj.check1, rj.check2, c1, c2);
    end
    rj.ans_a_valid = 1'b0;
    rj.ans_b_valid = 1'b0;
    tick();
    n_checks++;
    if (rj.ready !== 1'b0 || rj.check1 !== 1'b0 || rj.check2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack drop: got r=%b c1=%b c2=%b want 000", name, rj.ready, rj.check1,
               rj.check2);
    end
    n_checks++;
    if (sk_updates !== base + 1) begin
      n_fail++;
      $display("FAIL %s score updates: got %0d want %0d", name, sk_updates, base + 1);
    end
    tick();
    if (prob + 1 >= NP) begin
      n_checks++;
      if (rj.game_over !== 1'b1 || rj.ready !== 1'b0 || rj.timer !== 24'd0 ||
          rj.lock_a !== 1'b0) begin
        n_fail++;
        $display("FAIL %s game end: got go=%b r=%b t=%0d la=%b want go=1 r=0 t=0 la=0",
                 name, rj.game_over, rj.ready, rj.timer, rj.lock_a);
      end
    end else begin
      n_checks++;
      if (rj.game_over !== 1'b0 || rj.timer !== 24'(R - 1) || rj.lock_a !== 1'b0 ||
          rj.lock_b !== 1'b0) begin
        n_fail++;
        $display("FAIL %s rearm: got go=%b t=%0d la=%b lb=%b want go=0 t=%0d locks 0",
                 name, rj.game_over, rj.timer, rj.lock_a, rj.lock_b, R - 1);
      end
    end
  endtask

  task automatic test_reset();
    greset = 1'b1;
    rj.start = 1'b0;
    rj.ans_a_valid = 1'b0; rj.ans_a = 2'b00;
    rj.ans_b_valid = 1'b0; rj.ans_b = 2'b00;
    tick();
    tick();
    n_checks++;
    if ({rj.ready, rj.check1, rj.check2, rj.lock_a, rj.lock_b, rj.game_over} !== 6'b0 ||
        rj.timer !== 24'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got r=%b c=%b%b l=%b%b go=%b t=%0d want all 0",
               rj.ready, rj.check1, rj.check2, rj.lock_a, rj.lock_b, rj.game_over, rj.timer);
    end
    greset = 1'b0;
    exp_score_a = 0;
    exp_score_b = 0;
    tick();
    n_checks++;
    if (rj.timer !== 24'd0 || rj.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle without start: got t=%0d r=%b want 0 0", rj.timer, rj.ready);
    end
  endtask

  task automatic test_start();
    rj.start = 1'b1;
    tick();
    rj.start = 1'b0;
    n_checks++;
    if (rj.timer !== 24'(R - 1) || rj.lock_a !== 1'b0 || rj.lock_b !== 1'b0 ||
        rj.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start load: got t=%0d la=%b lb=%b r=%b want t=%0d 0 0 0",
               rj.timer, rj.lock_a, rj.lock_b, rj.ready, R - 1);
    end
  endtask

  task automatic test_both_correct();
    clear_plan();
    a_v[3] = 1'b1; a_d[3] = 2'b10;
    b_v[5] = 1'b1; b_d[5] = 2'b10;
    run_round("both_correct", 0);
  endtask

  task automatic test_lock_timeout();
    clear_plan();
    a_v[2] = 1'b1; a_d[2] = 2'b01;
    a_v[6] = 1'b1; a_d[6] = 2'b10;
    run_round("lock_timeout", 1);
  endtask

  task automatic test_simultaneous();
    clear_plan();
    b_v[R] = 1'b1; b_d[R] = 2'b11;
    run_round("simultaneous", 2);
  endtask

  task automatic test_full_game();
    n_checks++;
    if (sk_updates !== 3 || sk_score_a !== exp_score_a || sk_score_b !== exp_score_b) begin
      n_fail++;
      $display("FAIL full_game scores: got n=%0d a=%0d b=%0d want n=3 a=%0d b=%0d",
               sk_updates, sk_score_a, sk_score_b, exp_score_a, exp_score_b);
    end
    rj.start = 1'b1;
    tick();
    rj.start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (rj.game_over !== 1'b1 || rj.ready !== 1'b0 || rj.timer !== 24'd0 ||
        sk_updates !== 3) begin
      n_fail++;
      $display("FAIL done ignores start: got go=%b r=%b t=%0d n=%0d want 1 0 0 3",
               rj.game_over, rj.ready, rj.timer, sk_updates);
    end
  endtask

  task automatic test_reset_mid_verdict();
    test_reset();
    test_start();
    rj.ans_a_valid = 1'b1; rj.ans_a = 2'b10;
    tick();
    rj.ans_a_valid = 1'b0;
    rj.ans_b_valid = 1'b1; rj.ans_b = 2'b00;
    tick();
    rj.ans_b_valid = 1'b0;
    n_checks++;
    if (rj.ready !== 1'b1 || rj.check1 !== 1'b1 || rj.check2 !== 1'b0) begin
      n_fail++;
      $display("FAIL pre-reset verdict: got r=%b c1=%b c2=%b want 1 1 0", rj.ready, rj.check1,
               rj.check2);
    end
    greset = 1'b1;
    tick();
    greset = 1'b0;
    n_checks++;
    if (rj.ready !== 1'b0 || rj.check1 !== 1'b0 || rj.lock_a !== 1'b0 || rj.timer !== 24'd0) begin
      n_fail++;
      $display("FAIL reset mid verdict: got r=%b c1=%b la=%b t=%0d want 0 0 0 0",
               rj.ready, rj.check1, rj.lock_a, rj.timer);
    end
    tick();
    tick();
    n_checks++;
    if (sk_updates !== 0 || rj.ready !== 1'b0 || rj.timer !== 24'd0) begin
      n_fail++;
      $display("FAIL no extra update: got n=%0d r=%b t=%0d want 0 0 0", sk_updates, rj.ready,
               rj.timer);
    end
  endtask

  task automatic test_random();
    int k;
    logic [1:0] v;
    for (int g = 0; g < 6; g++) begin
      test_reset();
      test_start();
      for (int p = 0; p < NP; p++) begin
        clear_plan();
        // First strobe may land beyond the window (no answer) or anywhere inside it.
        k = $urandom_range(R + 4, 1);
        if (k <= R) begin
          a_v[k] = 1'b1; a_d[k] = 2'($urandom_range(3, 0));
          if (k < R && $urandom_range(1, 0) == 1) begin
            k = $urandom_range(R, k + 1);
            a_v[k] = 1'b1; a_d[k] = 2'($urandom_range(3, 0));
          end
        end
        k = $urandom_range(R + 4, 1);
        if (k <= R) begin
          v = 2'($urandom_range(3, 0));
          b_v[k] = 1'b1; b_d[k] = v;
          if (k < R) begin
            k = $urandom_range(R, k + 1);
            b_v[k] = 1'b1; b_d[k] = ~v;
          end
        end
        run_round("random", p);
      end
      n_checks++;
      if (sk_score_a !== exp_score_a || sk_score_b !== exp_score_b) begin
        n_fail++;
        $display("FAIL random game %0d scores: got a=%0d b=%0d want a=%0d b=%0d",
                 g, sk_score_a, sk_score_b, exp_score_a, exp_score_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_both_correct();
    test_lock_timeout();
    test_simultaneous();
    test_full_game();
    test_reset_mid_verdict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_judge.md
# round_judge

Per-question round controller for the two-player quiz game. It runs the answer window for each problem, latches each player's first answer, and judges it against a parameterised answer key. It then presents the verdict to the score keeper on the `ready`/`check1`/`check2` interface. It holds the verdict until the score keeper's one-cycle round-reset pulse arrives, then arms the next problem, up to a fixed game length.

## Interface
- `ROUND_CYCLES`, default 50_000_000: answer-window length in clk cycles, range 1..2^24.
- `NUM_PROBLEMS`, default 5: problems per game, range 1..7.
- `KEY`, default 16'h0000: answer key, 2 bits per problem. The key for problem p is `KEY[2p+1:2p]`.
- `clk`  in  1  clock.
- `greset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begins a game from IDLE; ignored in every other state.
- `problem`  in  3  current problem index from the score keeper.
- `round_ack`  in  1  round-reset pulse from the score keeper; acknowledges a verdict.
- `ans_a_valid`  in  1  player A answer strobe.
- `ans_a`  in  2  player A answer.
- `ans_b_valid`  in  1  player B answer strobe.
- `ans_b`  in  2  player B answer.
- `ready`  out  1  verdict valid; drives score keeper `ready`.
- `check1`  out  1  player A correct; drives score keeper `check1`.
- `check2`  out  1  player B correct; drives score keeper `check2`.
- `lock_a`  out  1  player A answer latched this round.
- `lock_b`  out  1  player B answer latched this round.
- `timer`  out  24  cycles remaining in the answer window.
- `game_over`  out  1  all problems played.

## Operation
- States:
  - IDLE: waiting for `start`.
  - ARMED: answer window open.
  - VERDICT: `ready` held, waiting for `round_ack`.
  - GAP: one cycle for `problem` to settle.
  - DONE: game finished.
- All outputs are registered. On `greset`: state=IDLE and every output is 0, including the latched answers and the timer.
- IDLE → ARMED when `start`=1. On entry, timer=ROUND_CYCLES-1 and `lock_a`=`lock_b`=0.
- ARMED, each edge:
  - If `ans_a_valid` and !`lock_a`: latch `ans_a` and set `lock_a`. Player B behaves the same with `ans_b_valid`/`ans_b`/`lock_b`.
  - Strobes received after a player is locked are ignored; the first answer wins.
  - Timer decrements by 1 per cycle.
- ARMED → VERDICT when timer==0, or when both locks are set. This includes the edge on which the second lock is being set.
  - Answers strobed on the transition edge are still captured.
  - On the transition edge, load `check1` = locked_a && (latched_a == key[problem]); `check2` likewise for player B. `ready` goes to 1.
  - A player with no answer is judged wrong.
- VERDICT: `ready`, `check1` and `check2` are held constant until `round_ack` is sampled 1. On that edge: `ready`=`check1`=`check2`=0, next state=GAP.
- GAP (1 cycle):
  - If `problem` >= NUM_PROBLEMS: → DONE, with `game_over`=1.
  - Else → ARMED, with the timer reloaded and the locks cleared.
- DONE: all outputs other than `game_over` are held at 0. Only `greset` leaves DONE.
- `round_ack` outside VERDICT is ignored.
- Key index is `problem` truncated to 3 bits. `problem` values >= 8 are impossible.

## Timing
- The score keeper registers its counters and its round-reset pulse. The handshake therefore runs as follows:
  - Edge E0: `ready` rises.
  - Edge E1: the score keeper counts and raises `round_ack`.
  - Edge E2: `ready` falls.
  - This yields exactly one score update per round. `ready` must never be high for more than one cycle after `round_ack` is seen.
- Latency from the last answer (both players locked) to `ready` is 1 cycle. Latency from timer==0 to `ready` is 1 cycle.
- Round period with no answers: ROUND_CYCLES + 1 (ready) + 1 (ack) + 1 (GAP) cycles.
- `greset` mid-round or in VERDICT drops `ready` on the next edge and returns to IDLE. The score keeper is reset by the same `greset`.

## Test plan
- Reset and start:
  - Hold `greset` for 2 cycles → all outputs 0, state IDLE.
  - Pulse `start` → `timer`=ROUND_CYCLES-1 next cycle, then decrements by 1 per cycle.
- Both players correct early:
  - Setup: ROUND_CYCLES=20, KEY[1:0]=2'b10.
  - Stimulus: A strobes 2'b10 at cycle 3, B strobes 2'b10 at cycle 5.
  - Response: `ready`=1 with `check1`=`check2`=1 at cycle 6. After the score keeper model's `round_ack`, `ready` drops after exactly 2 cycles high.
- First-answer lock and timeout:
  - Stimulus: A strobes 2'b01, then 2'b10 (the key), B never answers.
  - Response: `lock_a`=1 after the first strobe. The verdict comes at timer expiry with `check1`=0, `check2`=0.
- Simultaneous events: B strobes the correct answer on the timer==0 cycle → the answer is captured, `check2`=1.
- Full game:
  - Setup: NUM_PROBLEMS=3, paired with the score keeper model.
  - Stimulus: play 3 rounds.
  - Response: the score keeper's `problem` counts 1,2,3, then `game_over`=1 and `ready` stays 0. A further `start` is ignored.
- Reset mid-VERDICT: assert `greset` while `ready`=1 → `ready`=0 and IDLE next edge. No extra score update occurs.
